// File: rtl/operand_fetch_stage.sv
// ---------------------------------------------------------------------------
// operand_fetch_stage
//   Decode / operand-fetch stage that sits between instruction fetch and
//   execute. It drives the read addresses of a 16x32 2R1W register file
//   whose read data arrives one cycle after the address. It holds one
//   instruction and returns its operands with these adjustments:
//     - write-back bypass for a write that lands on the same edge as the
//       register-file read
//     - R15 reads return pc + 8
//     - a load-use interlock against an LDR that is currently in execute
//
// Ports
//   clk_i, reset_i            clock, synchronous active-high reset
//   in_valid_i / in_ready_o   fetch-side handshake
//   instr_i, pc_i             instruction word and its address
//   rf_rd_addr1_o/2_o         register-file read addresses (Rn, Rm or Rd)
//   rf_rd_data1_i/2_i         register-file read data, one cycle later
//   wb_en_i/addr_i/data_i     write-back port (same as the RF write port)
//   ex_load_i, ex_load_rd_i   LDR in execute and its destination
//   out_valid_o / out_ready_i execute-side handshake
//   op_a_o, op_b_o            operands after bypass and R15 substitution
//   rd_o, cond_o, opcode_o, imm_sel_o, imm12_o, set_flags_o,
//   is_load_o, is_store_o, is_branch_o, br_off_o, pc_o
//                             decoded fields of the held instruction
// ---------------------------------------------------------------------------
module operand_fetch_stage #(
  parameter int DW = 32,
  parameter int AW = 4
) (
  input  logic          clk_i,
  input  logic          reset_i,
  input  logic          in_valid_i,
  output logic          in_ready_o,
  input  logic [31:0]   instr_i,
  input  logic [31:0]   pc_i,
  output logic [AW-1:0] rf_rd_addr1_o,
  output logic [AW-1:0] rf_rd_addr2_o,
  input  logic [DW-1:0] rf_rd_data1_i,
  input  logic [DW-1:0] rf_rd_data2_i,
  input  logic          wb_en_i,
  input  logic [AW-1:0] wb_addr_i,
  input  logic [DW-1:0] wb_data_i,
  input  logic          ex_load_i,
  input  logic [AW-1:0] ex_load_rd_i,
  output logic          out_valid_o,
  input  logic          out_ready_i,
  output logic [DW-1:0] op_a_o,
  output logic [DW-1:0] op_b_o,
  output logic [AW-1:0] rd_o,
  output logic [3:0]    cond_o,
  output logic [3:0]    opcode_o,
  output logic          imm_sel_o,
  output logic [11:0]   imm12_o,
  output logic          set_flags_o,
  output logic          is_load_o,
  output logic          is_store_o,
  output logic          is_branch_o,
  output logic [DW-1:0] br_off_o,
  output logic [31:0]   pc_o
);

  localparam logic [AW-1:0] PC_REG = AW'(15);

  logic          valid_q;
  logic          fresh_q;
  logic [31:0]   instr_q;
  logic [31:0]   pc_q;
  logic          byp1_q;
  logic          byp2_q;
  logic [DW-1:0] bdat1_q;
  logic [DW-1:0] bdat2_q;

  logic          acc;
  logic          hazard;
  logic          is_dp;
  logic          is_ls;
  logic          store_q;
  logic          store_in;
  logic          src2_read;
  logic [AW-1:0] src1_q;
  logic [AW-1:0] src2_q;
  logic [AW-1:0] src1_in;
  logic [AW-1:0] src2_in;
  logic [DW-1:0] pc_plus8;

  // Decode of the held instruction
  assign is_dp   = (instr_q[27:26] == 2'b00);
  assign is_ls   = (instr_q[27:26] == 2'b01);
  assign store_q = is_ls && !instr_q[20];
  assign src1_q  = AW'(instr_q[19:16]);
  assign src2_q  = store_q ? AW'(instr_q[15:12]) : AW'(instr_q[3:0]);

  // Port 2 only matters for the interlock when the instruction really uses
  // it: register operand 2, register offset, or the data of a store.
  assign src2_read = (is_dp && !instr_q[25]) || (is_ls && instr_q[25]) || store_q;

  // Source addresses of the incoming instruction
  assign store_in = (instr_i[27:26] == 2'b01) && !instr_i[20];
  assign src1_in  = AW'(instr_i[19:16]);
  assign src2_in  = store_in ? AW'(instr_i[15:12]) : AW'(instr_i[3:0]);

  assign hazard = valid_q && ex_load_i &&
                  ((ex_load_rd_i == src1_q) || (src2_read && (ex_load_rd_i == src2_q)));

  // fresh_q covers the register-file read latency after an accept
  assign out_valid_o = valid_q && !hazard && !fresh_q;
  assign in_ready_o  = !valid_q || (out_ready_i && out_valid_o);
  assign acc         = in_valid_i && in_ready_o;

  // Re-reading the held sources whenever nothing new is accepted keeps the
  // RF data tracking the held instruction through stalls and hazards.
  assign rf_rd_addr1_o = acc ? src1_in : src1_q;
  assign rf_rd_addr2_o = acc ? src2_in : src2_q;

  assign pc_plus8 = DW'(pc_q + 32'd8);

  // R15 wins over the bypass; outputs read as zero while nothing is held
  always_comb begin
    op_a_o = '0;
    op_b_o = '0;
    if (valid_q) begin
      if (src1_q == PC_REG) op_a_o = pc_plus8;
      else if (byp1_q)      op_a_o = bdat1_q;
      else                  op_a_o = rf_rd_data1_i;

      if (src2_q == PC_REG) op_b_o = pc_plus8;
      else if (byp2_q)      op_b_o = bdat2_q;
      else                  op_b_o = rf_rd_data2_i;
    end
  end

  assign rd_o        = AW'(instr_q[15:12]);
  assign cond_o      = instr_q[31:28];
  assign opcode_o    = instr_q[24:21];
  assign imm_sel_o   = is_dp ? instr_q[25] : (is_ls ? !instr_q[25] : 1'b0);
  assign imm12_o     = instr_q[11:0];
  assign set_flags_o = is_dp && instr_q[20];
  assign is_load_o   = is_ls && instr_q[20];
  assign is_store_o  = store_q;
  assign is_branch_o = (instr_q[27:25] == 3'b101);
  assign br_off_o    = DW'({{6{instr_q[23]}}, instr_q[23:0], 2'b00});
  assign pc_o        = pc_q;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      valid_q <= 1'b0;
      fresh_q <= 1'b0;
      instr_q <= '0;
      pc_q    <= '0;
      byp1_q  <= 1'b0;
      byp2_q  <= 1'b0;
      bdat1_q <= '0;
      bdat2_q <= '0;
    end else begin
      // A write on the same edge as the read returns stale RF data, so the
      // written value is captured here and substituted next cycle.
      byp1_q  <= wb_en_i && (wb_addr_i == rf_rd_addr1_o);
      byp2_q  <= wb_en_i && (wb_addr_i == rf_rd_addr2_o);
      bdat1_q <= wb_data_i;
      bdat2_q <= wb_data_i;
      fresh_q <= acc;
      if (acc) begin
        valid_q <= 1'b1;
        instr_q <= instr_i;
        pc_q    <= pc_i;
      end else if (out_valid_o && out_ready_i) begin
        valid_q <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_operand_fetch_stage.sv
module tb_operand_fetch_stage;

  localparam int DW = 32;
  localparam int AW = 4;

  logic          clk_i = 1'b0;
  logic          reset_i;
  logic          in_valid_i;
  logic          in_ready_o;
  logic [31:0]   instr_i;
  logic [31:0]   pc_i;
  logic [AW-1:0] rf_rd_addr1_o;
  logic [AW-1:0] rf_rd_addr2_o;
  logic [DW-1:0] rf_rd_data1_i;
  logic [DW-1:0] rf_rd_data2_i;
  logic          wb_en_i;
  logic [AW-1:0] wb_addr_i;
  logic [DW-1:0] wb_data_i;
  logic          ex_load_i;
  logic [AW-1:0] ex_load_rd_i;
  logic          out_valid_o;
  logic          out_ready_i;
  logic [DW-1:0] op_a_o;
  logic [DW-1:0] op_b_o;
  logic [AW-1:0] rd_o;
  logic [3:0]    cond_o;
  logic [3:0]    opcode_o;
  logic          imm_sel_o;
  logic [11:0]   imm12_o;
  logic          set_flags_o;
  logic          is_load_o;
  logic          is_store_o;
  logic          is_branch_o;
  logic [DW-1:0] br_off_o;
  logic [31:0]   pc_o;

  operand_fetch_stage #(.DW(DW), .AW(AW)) dut (
    .clk_i(clk_i), .reset_i(reset_i),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
    .instr_i(instr_i), .pc_i(pc_i),
    .rf_rd_addr1_o(rf_rd_addr1_o), .rf_rd_addr2_o(rf_rd_addr2_o),
    .rf_rd_data1_i(rf_rd_data1_i), .rf_rd_data2_i(rf_rd_data2_i),
    .wb_en_i(wb_en_i), .wb_addr_i(wb_addr_i), .wb_data_i(wb_data_i),
    .ex_load_i(ex_load_i), .ex_load_rd_i(ex_load_rd_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
    .op_a_o(op_a_o), .op_b_o(op_b_o), .rd_o(rd_o),
    .cond_o(cond_o), .opcode_o(opcode_o), .imm_sel_o(imm_sel_o),
    .imm12_o(imm12_o), .set_flags_o(set_flags_o),
    .is_load_o(is_load_o), .is_store_o(is_store_o), .is_branch_o(is_branch_o),
    .br_off_o(br_off_o), .pc_o(pc_o)
  );

  always #5 clk_i = ~clk_i;

  // Register file model: registered read, read-before-write on the same edge
  logic [31:0] rf [16];
  always @(posedge clk_i) begin
    if (reset_i) begin
      for (int i = 0; i < 16; i++) rf[i] <= 32'h1000 + 32'(i);
      rf[2] <= 32'd5;
      rf[3] <= 32'd7;
      rf_rd_data1_i <= '0;
      rf_rd_data2_i <= '0;
    end else begin
      rf_rd_data1_i <= rf[rf_rd_addr1_o];
      rf_rd_data2_i <= rf[rf_rd_addr2_o];
      if (wb_en_i) rf[wb_addr_i] <= wb_data_i;
    end
  end

  // flags = {is_load, is_store, is_branch, imm_sel, set_flags}
  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  rd;
    logic [4:0]  fl;
    logic [31:0] br;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   vectors = 0;
  int   miscompares = 0;
  int   pops = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    vectors++;
    if (act !== expv) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", nm, act, expv);
    end
  endtask

  function automatic exp_t mk(input logic [31:0] a, input logic [31:0] b,
                              input logic [3:0] rd, input logic [4:0] fl,
                              input logic [31:0] br);
    exp_t e;
    e.a = a; e.b = b; e.rd = rd; e.fl = fl; e.br = br;
    return e;
  endfunction

  // Monitor: pops one expectation per downstream handshake
  always @(negedge clk_i) begin
    if (!reset_i && out_valid_o && out_ready_i) begin
      if (exp_q.size() == 0) begin
        chk("spurious_out_valid", 32'(out_valid_o), 32'd0);
      end else begin
        mon_e = exp_q.pop_front();
        pops++;
        $display("txn %0d: pc=%h op_a=%h op_b=%h rd=%0d", pops, pc_o, op_a_o, op_b_o, rd_o);
        chk("op_a", op_a_o, mon_e.a);
        chk("op_b", op_b_o, mon_e.b);
        chk("rd", 32'(rd_o), 32'(mon_e.rd));
        chk("flags", 32'({is_load_o, is_store_o, is_branch_o, imm_sel_o, set_flags_o}),
            32'(mon_e.fl));
        if (mon_e.fl[2]) chk("br_off", br_off_o, mon_e.br);
      end
    end
  end

  task automatic issue(input logic [31:0] ins, input logic [31:0] pc, input exp_t e);
    int n;
    exp_q.push_back(e);
    instr_i = ins;
    pc_i = pc;
    in_valid_i = 1'b1;
    #1;
    n = 0;
    while (!in_ready_o && n < 50) begin
      @(posedge clk_i); #1;
      n++;
    end
    if (!in_ready_o) chk("accept_timeout", 32'(in_ready_o), 32'd1);
    @(posedge clk_i); #1;
    in_valid_i = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk_i);
    #1;
  endtask

  localparam logic [31:0] ADD = 32'hE082_1003;  // ADD r1,r2,r3
  localparam logic [31:0] MOV = 32'hE1A0_000F;  // MOV r0,pc
  localparam logic [31:0] BR  = 32'hEAFF_FFFE;  // B -2
  localparam logic [31:0] LDR = 32'hE595_4004;  // LDR r4,[r5,#4]
  localparam logic [31:0] STR = 32'hE587_6000;  // STR r6,[r7]

  initial begin
    int n;
    reset_i = 1'b1; in_valid_i = 1'b1; instr_i = ADD; pc_i = 32'h40;
    wb_en_i = 1'b0; wb_addr_i = '0; wb_data_i = '0;
    ex_load_i = 1'b0; ex_load_rd_i = '0; out_ready_i = 1'b1;

    // Reset with in_valid held high
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    chk("reset_out_valid", 32'(out_valid_o), 32'd0);
    @(posedge clk_i); #1;
    reset_i = 1'b0; in_valid_i = 1'b0;
    @(negedge clk_i);
    chk("rst_out_valid", 32'(out_valid_o), 32'd0);
    chk("rst_in_ready", 32'(in_ready_o), 32'd1);
    chk("rst_op_a", op_a_o, 32'd0);
    chk("rst_op_b", op_b_o, 32'd0);
    chk("rst_pc", pc_o, 32'd0);
    chk("rst_fields", 32'({rd_o, cond_o, opcode_o, imm12_o, is_branch_o, set_flags_o}), 32'd0);
    chk("rst_br_off", br_off_o, 32'd0);

    // Plain ADD
    @(posedge clk_i); #1;
    instr_i = ADD; pc_i = 32'h40; in_valid_i = 1'b1;
    #1;
    chk("addr1", 32'(rf_rd_addr1_o), 32'd2);
    chk("addr2", 32'(rf_rd_addr2_o), 32'd3);
    issue(ADD, 32'h40, mk(32'd5, 32'd7, 4'd1, 5'b00000, 32'd0));
    @(negedge clk_i);
    chk("fill_bubble", 32'(out_valid_o), 32'd0);

    // ADD with write-back to r2 on the accept edge
    @(posedge clk_i); #1;
    wb_en_i = 1'b1; wb_addr_i = 4'd2; wb_data_i = 32'h99;
    issue(ADD, 32'h44, mk(32'h99, 32'd7, 4'd1, 5'b00000, 32'd0));
    wb_en_i = 1'b0;
    idle(3);

    // Load-use hazard on r3; r3 is rewritten during the hazard
    issue(ADD, 32'h48, mk(32'h99, 32'h33, 4'd1, 5'b00000, 32'd0));
    ex_load_i = 1'b1; ex_load_rd_i = 4'd3;
    @(negedge clk_i);
    chk("hz_fresh", 32'(out_valid_o), 32'd0);
    @(posedge clk_i); #1;
    wb_en_i = 1'b1; wb_addr_i = 4'd3; wb_data_i = 32'h33;
    @(negedge clk_i);
    chk("hz_cycle1", 32'(out_valid_o), 32'd0);
    @(posedge clk_i); #1;
    wb_en_i = 1'b0;
    @(negedge clk_i);
    chk("hz_cycle2", 32'(out_valid_o), 32'd0);
    chk("hz_in_ready", 32'(in_ready_o), 32'd0);
    @(posedge clk_i); #1;
    ex_load_i = 1'b0;

    // R15 substitution and branch offset, back to back
    issue(MOV, 32'h100, mk(32'h1000, 32'h108, 4'd0, 5'b00000, 32'd0));
    issue(BR, 32'h200, mk(32'h208, 32'h100E, 4'd15, 5'b00100, 32'hFFFF_FFF8));

    // Load and store; an LDR to r4 in execute must not stall either
    ex_load_i = 1'b1; ex_load_rd_i = 4'd4;
    issue(LDR, 32'h300, mk(32'h1005, 32'h1004, 4'd4, 5'b10010, 32'd0));
    issue(STR, 32'h304, mk(32'h1007, 32'h1006, 4'd6, 5'b01010, 32'd0));
    chk("ldr_no_stall_pops", 32'(pops), 32'd6);
    idle(2);
    ex_load_i = 1'b0;
    idle(2);

    // Downstream stall with a write-back to r2 in the middle
    issue(ADD, 32'h400, mk(32'hAB, 32'h33, 4'd1, 5'b00000, 32'd0));
    out_ready_i = 1'b0;
    @(negedge clk_i);
    @(negedge clk_i);
    chk("stall_valid", 32'(out_valid_o), 32'd1);
    chk("stall_in_ready", 32'(in_ready_o), 32'd0);
    chk("stall_op_a0", op_a_o, 32'h99);
    chk("stall_addr1", 32'(rf_rd_addr1_o), 32'd2);
    @(posedge clk_i); #1;
    wb_en_i = 1'b1; wb_addr_i = 4'd2; wb_data_i = 32'hAB;
    @(posedge clk_i); #1;
    wb_en_i = 1'b0;
    @(negedge clk_i);
    chk("stall_op_a_byp", op_a_o, 32'hAB);
    chk("stall_in_ready2", 32'(in_ready_o), 32'd0);
    @(negedge clk_i);
    chk("stall_op_a_rf", op_a_o, 32'hAB);
    chk("stall_op_b", op_b_o, 32'h33);
    chk("stall_pc", pc_o, 32'h400);
    @(posedge clk_i); #1;
    out_ready_i = 1'b1;

    // Drain
    n = 0;
    while (exp_q.size() != 0 && n < 20) begin
      @(posedge clk_i);
      n++;
    end
    idle(2);
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    chk("total_pops", 32'(pops), 32'd8);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
